md_unit: RTL and testbench

MD_UNIT -- requirements
Module: md_unit

---
 rtl/md_unit_pkg.sv | 45 ++++
 rtl/md_unit.sv | 123 ++++++++++++
 tb/tb_md_unit.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared CPU encodings: ALU ops, multiply/divide ops and the md_unit FSM states.
// Also holds the default latencies used by md_unit.
package md_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11
  } alu_op_e;

  typedef enum logic [3:0] {
    MD_NONE  = 4'd0,
    MD_MULT  = 4'd1,
    MD_MULTU = 4'd2,
    MD_DIV   = 4'd3,
    MD_DIVU  = 4'd4,
    MD_MTHI  = 4'd5,
    MD_MTLO  = 4'd6,
    MD_MFHI  = 4'd7,
    MD_MFLO  = 4'd8
  } md_op_e;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  // Ops that occupy the unit for a multi-cycle latency
  function automatic logic md_is_long_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit with HI/LO registers; arithmetic is single-cycle,
// the visible latency comes from a down-counter in a two-state FSM.
module md_unit
  import md_unit_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  input  logic [3:0]  md_op,
  output logic        busy,
  output logic [31:0] md_out
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES + 1);
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
  localparam logic [CW-1:0] CNT_LAST  = CW'(1);

  md_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] opA_q, opB_q;
  md_op_e      opSel_q;

  logic [63:0] prod_d;
  logic [31:0] resHi_d, resLo_d;

  // Results derive only from operands captured at launch; a zero divisor
  // and unknown ops fall through to the current HI/LO so the write is a no-op.
  always_comb begin
    prod_d  = '0;
    resHi_d = hi_q;
    resLo_d = lo_q;
    case (opSel_q)
      MD_MULT: begin
        prod_d  = {{32{opA_q[31]}}, opA_q} * {{32{opB_q[31]}}, opB_q};
        resHi_d = prod_d[63:32];
        resLo_d = prod_d[31:0];
      end
      MD_MULTU: begin
        prod_d  = {32'b0, opA_q} * {32'b0, opB_q};
        resHi_d = prod_d[63:32];
        resLo_d = prod_d[31:0];
      end
      MD_DIV: begin
        if (opB_q != 32'd0) begin
          if (opA_q == 32'h8000_0000 && opB_q == 32'hFFFF_FFFF) begin
            resLo_d = 32'h8000_0000;
            resHi_d = 32'h0000_0000;
          end else begin
            resLo_d = $signed(opA_q) / $signed(opB_q);
            resHi_d = $signed(opA_q) % $signed(opB_q);
          end
        end
      end
      MD_DIVU: begin
        if (opB_q != 32'd0) begin
          resLo_d = opA_q / opB_q;
          resHi_d = opA_q % opB_q;
        end
      end
      default: ;
    endcase
  end

  // Control FSM; HI/LO are committed on the same edge that returns to IDLE
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      opA_q   <= '0;
      opB_q   <= '0;
      opSel_q <= MD_NONE;
    end else begin
      case (state_q)
        MD_IDLE: begin
          if (md_is_long_op(md_op)) begin
            opA_q   <= rs;
            opB_q   <= rt;
            opSel_q <= md_op_e'(md_op);
            cnt_q   <= (md_op == MD_MULT || md_op == MD_MULTU) ? MULT_LOAD : DIV_LOAD;
            busy_q  <= 1'b1;
            state_q <= MD_BUSY;
          end else if (md_op == MD_MTHI) begin
            hi_q <= rs;
          end else if (md_op == MD_MTLO) begin
            lo_q <= rs;
          end
        end
        MD_BUSY: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            hi_q    <= resHi_d;
            lo_q    <= resLo_d;
            state_q <= MD_IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_LAST;
          end
        end
        default: state_q <= MD_IDLE;
      endcase
    end
  end

  assign busy = busy_q;

  always_comb begin
    md_out = '0;
    if (md_op == MD_MFHI) md_out = hi_q;
    else if (md_op == MD_MFLO) md_out = lo_q;
  end

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: the driver steps an arithmetic reference model and
// queues expected reads and busy lengths; a negedge monitor pops and compares them.
module tb_md_unit;
  import md_unit_pkg::*;

  localparam int MULTN = 5;
  localparam int DIVN  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] rs = '0, rt = '0;
  logic [3:0]  md_op = '0;
  logic        busy;
  logic [31:0] md_out;

  int checks = 0;
  int errors = 0;

  logic [31:0] outQ[$];
  int          busyQ[$];
  int          busyRun = 0;

  logic [31:0] mHi = '0, mLo = '0;
  logic [31:0] pHi, pLo;
  bit          pWr;
  int          mLeft = 0;

  md_unit #(.MULT_CYCLES(MULTN), .DIV_CYCLES(DIVN)) dut (
    .clk(clk), .reset(reset), .rs(rs), .rt(rt),
    .md_op(md_op), .busy(busy), .md_out(md_out)
  );

  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference arithmetic from magnitudes and signs, using 64-bit integers
  task automatic modelCompute(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r, p, qa;
    longint unsigned ua, ub, pu;
    pWr = 1'b1;
    pHi = mHi;
    pLo = mLo;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op == MD_MULT) begin
      p = sa * sb;
      pHi = p[63:32];
      pLo = p[31:0];
    end else if (op == MD_MULTU) begin
      pu = ua * ub;
      pHi = pu[63:32];
      pLo = pu[31:0];
    end else if (b == 32'd0) begin
      pWr = 1'b0;
    end else if (op == MD_DIV) begin
      qa = (sa < 0 ? -sa : sa) / (sb < 0 ? -sb : sb);
      q = ((sa < 0) != (sb < 0)) ? -qa : qa;
      r = sa - q * sb;
      pLo = q[31:0];
      pHi = r[31:0];
    end else begin
      pLo = 32'(ua / ub);
      pHi = 32'(ua % ub);
    end
  endtask

  // Drive one cycle and advance the model across the edge that follows
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    @(posedge clk);
    #1;
    md_op = op;
    rs = a;
    rt = b;
    if (op == MD_MFHI) outQ.push_back(mHi);
    else if (op == MD_MFLO) outQ.push_back(mLo);
    if (mLeft == 0) begin
      if (op inside {[1:4]}) begin
        modelCompute(op, a, b);
        mLeft = (op <= 4'd2) ? MULTN : DIVN;
        busyQ.push_back(mLeft);
      end else if (op == MD_MTHI) begin
        mHi = a;
      end else if (op == MD_MTLO) begin
        mLo = a;
      end
    end else begin
      mLeft--;
      if (mLeft == 0 && pWr) begin
        mHi = pHi;
        mLo = pLo;
      end
    end
  endtask

  task automatic waitIdle();
    while (mLeft != 0) applyStimulus(MD_NONE, $urandom, $urandom);
  endtask

  task automatic readBoth();
    applyStimulus(MD_MFHI, $urandom, $urandom);
    applyStimulus(MD_MFLO, $urandom, $urandom);
  endtask

  // Reset raised between edges; optionally checks that clearing is immediate
  task automatic resetPulse(input bit checkNow);
    @(posedge clk);
    #2;
    reset = 1'b1;
    md_op = MD_NONE;
    mHi = '0;
    mLo = '0;
    mLeft = 0;
    busyQ.delete();
    if (checkNow) begin
      #1;
      checkOutput("busyAtReset", {31'b0, busy}, 32'd0);
      md_op = MD_MFHI;
      #1;
      checkOutput("hiAtReset", md_out, 32'd0);
      md_op = MD_MFLO;
      #1;
      checkOutput("loAtReset", md_out, 32'd0);
      md_op = MD_NONE;
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  function automatic logic [31:0] randOperand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      busyRun = 0;
    end else begin
      if (busy) begin
        busyRun++;
      end else if (busyRun > 0) begin
        if (busyQ.size() == 0) checkOutput("busyUnexpected", 32'(busyRun), 32'd0);
        else checkOutput("busyLength", 32'(busyRun), 32'(busyQ.pop_front()));
        busyRun = 0;
      end
      if (md_op == MD_MFHI || md_op == MD_MFLO) begin
        if (outQ.size() == 0) checkOutput("readUnexpected", md_out, 32'hxxxx_xxxx);
        else checkOutput(md_op == MD_MFHI ? "mfhi" : "mflo", md_out, outQ.pop_front());
      end
    end
  end

  initial begin
    logic [3:0] op;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("busyAfterReset", {31'b0, busy}, 32'd0);
    readBoth();

    applyStimulus(MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    waitIdle();
    readBoth();

    applyStimulus(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    waitIdle();
    readBoth();

    applyStimulus(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    applyStimulus(MD_MFLO, $urandom, $urandom);
    waitIdle();
    readBoth();

    applyStimulus(MD_MTHI, 32'h1234_5678, 32'd0);
    applyStimulus(MD_DIVU, 32'd7, 32'd0);
    waitIdle();
    readBoth();

    applyStimulus(MD_MULT, 32'd3, 32'hFFFF_FFFB);
    applyStimulus(MD_MTLO, 32'hDEAD_BEEF, 32'd0);
    applyStimulus(MD_MULT, 32'd100, 32'd100);
    applyStimulus(MD_MTHI, 32'hCAFE_F00D, 32'd0);
    waitIdle();
    readBoth();

    applyStimulus(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitIdle();
    readBoth();

    applyStimulus(MD_DIV, 32'd1000, 32'd7);
    repeat (3) applyStimulus(MD_NONE, $urandom, $urandom);
    resetPulse(1'b1);
    repeat (DIVN + 2) applyStimulus(MD_NONE, $urandom, $urandom);
    readBoth();

    resetPulse(1'b0);
    applyStimulus(MD_MULTU, 32'd3, 32'd4);
    waitIdle();
    readBoth();

    for (int i = 0; i < 400; i++) begin
      op = 4'($urandom_range(0, 15));
      applyStimulus(op, randOperand(), randOperand());
    end
    waitIdle();
    readBoth();

    repeat (DIVN + 5) applyStimulus(MD_NONE, '0, '0);
    checkOutput("busyQueueDrained", 32'(busyQ.size()), 32'd0);
    checkOutput("readQueueDrained", 32'(outQ.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
